// File: rtl/async_tx_fifo.sv
// async_tx_fifo: UART transmitter (8 data bits, no parity, 1/2 stop bits, LSB first) fed by a byte FIFO.
// Latency: txd falls 2 cycles after a push into an idle, empty block; pushes while full are dropped (txd_ready low).
module async_tx_fifo #(
   parameter int clk_freq  = 25000000,
   parameter int baud      = 115200,
   parameter int stop_bits = 1,
   parameter int fifo_aw   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               txd_start,
   input  logic [7:0]         txd_data,
   output logic               txd_ready,
   output logic               txd,
   output logic               txd_busy,
   output logic [fifo_aw:0]   fifo_count
);
   localparam int DIV   = (clk_freq + baud / 2) / baud;
   localparam int DEPTH = 1 << fifo_aw;
   localparam int CW    = $clog2(DIV);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [fifo_aw:0] FULL_CNT = {1'b1, {fifo_aw{1'b0}}};

   generate
      if (DIV < 2 || stop_bits < 1 || stop_bits > 2) begin : g_bad_cfg
         $error("async_tx_fifo: baud divider below 2 or stop_bits not 1 or 2");
      end
   endgenerate

   logic [7:0]         mem [DEPTH];
   logic [fifo_aw-1:0] wr_ptr;
   logic [fifo_aw-1:0] rd_ptr;
   logic [fifo_aw:0]   count_nxt;
   logic [1:0]         state;
   logic [CW-1:0]      bit_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shreg;
   logic               bit_done;
   logic               last_stop;
   logic               push;
   logic               pop;

   assign bit_done  = (bit_cnt == CW'(DIV - 1));
   assign last_stop = (state == S_STOP) && bit_done && (bit_idx == 3'(stop_bits - 1));
   // Acceptance uses the pre-pop count, so a full FIFO rejects even in a pop cycle.
   assign push      = txd_start && (fifo_count < FULL_CNT);
   assign pop       = (fifo_count != '0) && ((state == S_IDLE) || last_stop);
   assign count_nxt = fifo_count + {{fifo_aw{1'b0}}, push} - {{fifo_aw{1'b0}}, pop};

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= txd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         txd        <= 1'b1;
         txd_busy   <= 1'b0;
         txd_ready  <= 1'b1;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + fifo_aw'(1);
         if (pop)  rd_ptr <= rd_ptr + fifo_aw'(1);
         fifo_count <= count_nxt;
         txd_ready  <= (count_nxt < FULL_CNT);
         // Every state change lands on bit_done, so the wrap doubles as the clear on entry.
         bit_cnt    <= bit_done ? '0 : bit_cnt + CW'(1);

         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  state    <= S_START;
                  txd      <= 1'b0;
                  txd_busy <= 1'b1;
               end
            end
            S_START: begin
               if (bit_done) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
                  txd     <= shreg[0];
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  shreg <= shreg >> 1;
                  if (bit_idx == 3'd7) begin
                     state   <= S_STOP;
                     bit_idx <= '0;
                     txd     <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[1];
                  end
               end
            end
            default: begin
               if (last_stop) begin
                  bit_idx <= '0;
                  if (pop) begin
                     shreg <= mem[rd_ptr];
                     state <= S_START;
                     txd   <= 1'b0;
                  end else begin
                     state    <= S_IDLE;
                     txd      <= 1'b1;
                     txd_busy <= 1'b0;
                  end
               end else if (bit_done) begin
                  bit_idx <= bit_idx + 3'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_async_tx_fifo.sv
// Bench for async_tx_fifo: directed steps plus random bytes, checked by a line-level UART receiver model.
module tb_async_tx_fifo;
   localparam int DIV = (1000000 + 50000) / 100000;
   localparam int FA  = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst_a, start_a, ready_a, txd_a, busy_a;
   logic [7:0] data_a;
   logic [2:0] count_a;
   logic       rst_b, start_b, ready_b, txd_b, busy_b;
   logic [7:0] data_b;
   logic [2:0] count_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic         mon_en = 1'b0;
   int           rx_k = 0;
   int           rx_n = 0;
   logic [127:0] rx_v;
   logic         rx_busy;
   logic [7:0]   exp_q[$];
   int           st_q[$];
   int           cnt_q[$];

   async_tx_fifo #(.clk_freq(1000000), .baud(100000), .stop_bits(1), .fifo_aw(2)) dut_a (
      .clk(clk), .rst(rst_a), .txd_start(start_a), .txd_data(data_a),
      .txd_ready(ready_a), .txd(txd_a), .txd_busy(busy_a), .fifo_count(count_a));

   async_tx_fifo #(.clk_freq(1000000), .baud(100000), .stop_bits(2), .fifo_aw(2)) dut_b (
      .clk(clk), .rst(rst_b), .txd_start(start_b), .txd_data(data_b),
      .txd_ready(ready_b), .txd(txd_b), .txd_busy(busy_b), .fifo_count(count_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ideal serial waveform of one frame, one entry per clock cycle; ones beyond the frame.
   function automatic logic [127:0] frame_exp(input logic [7:0] b, input int s);
      logic [127:0] v;
      v = '1;
      for (int k = 0; k < (9 + s) * DIV; k++) begin
         if (k < DIV) v[k] = 1'b0;
         else if (k < 9 * DIV) v[k] = b[k / DIV - 1];
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rx(input int n, input int bound);
      int i = 0;
      while (rx_n < n && i < bound) begin
         tick();
         i++;
      end
      check("rx_frames", rx_n, n);
   endtask

   // Receiver model on dut_a: captures a whole frame from its start edge and compares it.
   always @(negedge clk) begin
      if (!mon_en || rst_a) begin
         rx_k = 0;
      end else if (rx_k != 0 || txd_a === 1'b0) begin
         if (rx_k == 0) begin
            rx_v = '1;
            rx_busy = 1'b1;
            st_q.push_back(cyc);
         end
         rx_v[rx_k] = txd_a;
         rx_busy = rx_busy & busy_a;
         rx_k++;
         if (rx_k == FA) begin
            cnt_q.push_back(int'(count_a));
            check("frame_busy", rx_busy, 1'b1);
            if (exp_q.size() == 0) check("unexpected_frame", rx_v, '1);
            else check("frame_a", rx_v, frame_exp(exp_q.pop_front(), 1));
            rx_n++;
            rx_k = 0;
         end
      end
   end

   initial begin
      int n, sent, low, base;
      logic [127:0] v;
      logic [7:0] b;
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
      tick();
      check("rst_txd", txd_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_ready", ready_a, 1'b1);
      check("rst_count", count_a, 3'd0);
      tick();
      rst_a = 1'b0; rst_b = 1'b0;
      mon_en = 1'b1;
      tick();

      // Single byte 0xA5
      exp_q.push_back(8'hA5);
      start_a = 1'b1; data_a = 8'hA5;
      tick();
      start_a = 1'b0; data_a = 8'h00;
      check("push_count", count_a, 3'd1);
      check("push_txd_idle", txd_a, 1'b1);
      tick();
      check("pop_txd", txd_a, 1'b0);
      check("pop_busy", busy_a, 1'b1);
      check("pop_count", count_a, 3'd0);
      n = 0;
      while (busy_a === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      check("busy_len", n, FA);
      check("after_txd", txd_a, 1'b1);
      check("single_rx", rx_n, 1);

      // Burst of three, frames must be contiguous
      st_q.delete(); cnt_q.delete();
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
      start_a = 1'b1; data_a = 8'h00; tick(); check("burst_cnt1", count_a, 3'd1);
      data_a = 8'hFF; tick(); check("burst_cnt2", count_a, 3'd1);
      data_a = 8'h55; tick(); check("burst_cnt3", count_a, 3'd2);
      start_a = 1'b0;
      wait_rx(4, 500);
      if (st_q.size() == 3 && cnt_q.size() == 3) begin
         check("burst_gap1", st_q[1] - st_q[0], FA);
         check("burst_gap2", st_q[2] - st_q[1], FA);
         check("burst_cnt_f1", cnt_q[0], 2);
         check("burst_cnt_f2", cnt_q[1], 1);
         check("burst_cnt_f3", cnt_q[2], 0);
      end else begin
         check("burst_frames", st_q.size(), 3);
      end
      tick(); tick();

      // Overfill: six pushes into a depth-4 FIFO
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
      start_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_a = 8'h11 + 8'(i);
         tick();
         check("full_cnt", count_a, (i == 0) ? 3'd1 : (i >= 4) ? 3'd4 : 3'(i));
         check("full_ready", ready_a, (i >= 4) ? 1'b0 : 1'b1);
      end
      start_a = 1'b0;
      wait_rx(9, 700);
      tick();
      check("full_drain_cnt", count_a, 3'd0);
      check("full_drain_ready", ready_a, 1'b1);

      // Wrap-around stream 0x00..0x13, pushing whenever ready
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
      sent = 0; n = 0;
      while (sent < 20 && n < 3000) begin
         start_a = ready_a;
         data_a = 8'(sent);
         tick();
         if (start_a) sent++;
         n++;
      end
      start_a = 1'b0;
      check("wrap_sent", sent, 20);
      wait_rx(29, 2500);
      tick(); tick();

      // Random bursts that fit in the FIFO
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 5);
         base = rx_n;
         start_a = 1'b1;
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            data_a = b;
            exp_q.push_back(b);
            tick();
         end
         start_a = 1'b0;
         wait_rx(base + n, 700);
         tick(); tick();
      end

      // Reset mid-frame with two bytes still queued
      mon_en = 1'b0;
      exp_q.delete();
      start_a = 1'b1;
      data_a = 8'h77; tick();
      data_a = 8'h88; tick();
      data_a = 8'h99; tick();
      start_a = 1'b0;
      repeat (42) tick();
      check("mid_pre_cnt", count_a, 3'd2);
      check("mid_pre_busy", busy_a, 1'b1);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      check("mid_txd", txd_a, 1'b1);
      check("mid_busy", busy_a, 1'b0);
      check("mid_count", count_a, 3'd0);
      check("mid_ready", ready_a, 1'b1);
      low = 0;
      repeat (300) begin
         tick();
         if (txd_a !== 1'b1 || busy_a !== 1'b0) low++;
      end
      check("mid_quiet", low, 0);
      mon_en = 1'b1;
      base = rx_n;
      exp_q.push_back(8'h5A);
      start_a = 1'b1; data_a = 8'h5A; tick(); start_a = 1'b0;
      wait_rx(base + 1, 300);

      // Two stop bits on dut_b
      start_b = 1'b1; data_b = 8'h3C; tick();
      data_b = 8'hC3; tick();
      start_b = 1'b0;
      n = 0;
      while (txd_b !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("b_latency", n, 0);
      for (int f = 0; f < 2; f++) begin
         v = '1;
         for (int k = 0; k < 11 * DIV; k++) begin
            v[k] = txd_b;
            tick();
         end
         check("b_frame", v, frame_exp((f == 0) ? 8'h3C : 8'hC3, 2));
         if (f == 0) begin
            check("b_second_start", txd_b, 1'b0);
            check("b_busy_between", busy_b, 1'b1);
         end
      end
      check("b_end_busy", busy_b, 1'b0);
      check("b_end_txd", txd_b, 1'b1);
      check("b_end_count", count_b, 3'd0);
      check("b_end_ready", ready_b, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
